// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   - state_e      : control FSM encoding (IDLE=0, CONVERT=1, DONE=2)
//   - DIGITS_DEF   : default number of BCD digits accepted
//   - BIN_W_DEF    : default binary result width
//   - CNT_W_DEF    : step counter width for the default result width
package bcd_to_bin_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam int DIGITS_DEF = 3;
   localparam int BIN_W_DEF  = 10;
   localparam int CNT_W_DEF  = $clog2(BIN_W_DEF);

endpackage

// File: rtl/bcd_to_bin_seq_nibble_adj.sv
// Per-digit correction used by reverse double-dabble.
// After a right shift, a BCD digit that reads 8 or more received a bit that is
// worth 5 in decimal but 8 in binary weight, so 3 is taken away to realign it.
// Inputs never underflow because the subtraction only happens for values >= 8.
//   nib_in  : shifted BCD digit
//   nib_out : corrected BCD digit
module bcd_nibble_adj (
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);

   assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
//   clk    : system clock
//   rst    : asynchronous reset, active low
//   start  : conversion request, sampled only while idle
//   bcd_in : packed BCD digits, most significant digit in the top nibble
//   busy   : high while converting or presenting the result
//   done   : one-cycle pulse when result/err are valid
//   err    : last accepted request contained a digit greater than 9
//   result : binary value of the last conversion (0 on error)
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is idle (busy=0). Requests while busy are dropped, not queued. Exactly
// one done pulse follows each accepted request unless reset intervenes.
module bcd_to_bin_seq
   import bcd_to_bin_seq_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [BIN_W-1:0]    result
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W == BIN_W_DEF) ? CNT_W_DEF : $clog2(BIN_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

   state_e             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   result_q, result_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   // One step of the datapath: shift {bcd, bin} right, then fix each digit.
   logic [BCD_W+BIN_W-1:0] cat_sh;
   logic [BCD_W-1:0]       bcd_sh;
   logic [BIN_W-1:0]       bin_sh;
   logic [BCD_W-1:0]       bcd_adj;

   assign cat_sh = {bcd_q, bin_q} >> 1;
   assign bcd_sh = cat_sh[BIN_W +: BCD_W];
   assign bin_sh = cat_sh[BIN_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
         .nib_in  (bcd_sh[4*g +: 4]),
         .nib_out (bcd_adj[4*g +: 4])
      );
   end

   // Any input digit outside 0..9 makes the request invalid.
   logic bad_digit;
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bcd_d    = bcd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bcd_d = bcd_in;
               bin_d = '0;
               cnt_d = '0;
               if (bad_digit) begin
                  // Invalid digits skip the conversion entirely.
                  state_d  = ST_DONE;
                  err_d    = 1'b1;
                  result_d = '0;
               end else begin
                  state_d = ST_CONVERT;
                  err_d   = 1'b0;
               end
            end
         end
         ST_CONVERT: begin
            bcd_d = bcd_adj;
            bin_d = bin_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               // Final bit lands in bin_sh this cycle; publish it directly.
               state_d  = ST_DONE;
               result_d = bin_sh;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases, busy-drop, abort by
// reset, and a back-to-back sweep over every valid 3-digit input.
module tb_bcd_to_bin_seq;

   localparam int BIN_W = 10;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [11:0]      bcd_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [BIN_W-1:0] result;

   always #5 clk = ~clk;

   bcd_to_bin_seq #(.DIGITS(3), .BIN_W(BIN_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bcd_in (bcd_in),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int done_count = 0;
   int cyc = 0;
   int last_done_cyc = -1;
   bit spacing_on = 1'b0;
   logic [BIN_W:0] exp_q[$];   // {err, result}
   logic [BIN_W:0] exp_item;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Decimal reference model of a 3-digit BCD word.
   function automatic logic [BIN_W:0] model(input logic [11:0] b);
      logic e;
      int   v;
      e = 1'b0;
      v = 0;
      for (int i = 2; i >= 0; i--) begin
         if (b[4*i +: 4] > 4'd9) e = 1'b1;
         v = v * 10 + int'(b[4*i +: 4]);
      end
      return e ? {1'b1, {BIN_W{1'b0}}} : {1'b0, BIN_W'(v)};
   endfunction

   always @(posedge clk) cyc++;

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         done_count++;
         check_val("busy_at_done", busy, 1);
         check_val("exp_q_empty_at_done", 32'(exp_q.size() == 0), 0);
         if (exp_q.size() != 0) begin
            exp_item = exp_q.pop_front();
            check_val("result", result, exp_item[BIN_W-1:0]);
            check_val("err", err, exp_item[BIN_W]);
         end
         if (spacing_on && last_done_cyc >= 0)
            check_val("done_spacing", cyc - last_done_cyc, 12);
         last_done_cyc = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [11:0] b);
      @(negedge clk);
      bcd_in = b;
      start  = 1'b1;
      exp_q.push_back(model(b));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges until the next done pulse; bounded by budget.
   task automatic wait_done(input int budget, output int lat);
      int base;
      base = done_count;
      lat  = 0;
      while (done_count == base && lat < budget) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check_val("done_seen", 32'(done_count != base), 1);
   endtask

   // ---------------- stimulus ----------------
   logic [11:0] dir_tab[3] = '{12'h999, 12'h063, 12'h100};

   initial begin
      int lat;
      int dc;
      logic [11:0] b;

      rst = 1'b0;
      start = 1'b0;
      bcd_in = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_result", result, 0);
      @(negedge clk) rst = 1'b1;

      // Zero input: latency and busy shape.
      issue(12'h000);
      @(negedge clk);
      #1 check_val("busy_cycle1", busy, 1);
      wait_done(20, lat);
      check_val("lat_000", lat + 1, 11);
      @(negedge clk);
      #1 check_val("busy_after_done", busy, 0);
      check_val("done_after_done", done, 0);

      // Directed valid values.
      foreach (dir_tab[k]) begin
         issue(dir_tab[k]);
         wait_done(20, lat);
         check_val("lat_valid", lat, 11);
      end

      // Invalid digit, then recovery.
      issue(12'h0A5);
      wait_done(20, lat);
      check_val("lat_invalid", lat, 1);
      repeat (2) @(negedge clk);
      #1 check_val("err_held", err, 1);
      check_val("result_held_err", result, 0);
      issue(12'h042);
      wait_done(20, lat);
      check_val("lat_042", lat, 11);
      repeat (3) @(negedge clk);
      #1 check_val("result_held_42", result, 42);

      // Start while busy is dropped.
      dc = done_count;
      issue(12'h500);
      repeat (3) @(negedge clk);
      bcd_in = 12'h123;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(20, lat);
      repeat (15) @(negedge clk);
      check_val("single_done", done_count - dc, 1);
      check_val("q_drained_busy_drop", exp_q.size(), 0);

      // Reset during conversion aborts with no done pulse.
      issue(12'h777);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_result", result, 0);
      check_val("abort_err", err, 0);
      exp_q.delete();
      dc = done_count;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      #1 check_val("no_done_after_abort", done_count - dc, 0);
      check_val("result_after_abort", result, 0);
      issue(12'h777);
      wait_done(20, lat);
      check_val("lat_777", lat, 11);

      // Back-to-back sweep of all valid inputs with start held high.
      @(negedge clk);
      spacing_on = 1'b1;
      last_done_cyc = -1;
      start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
         bcd_in = b;
         exp_q.push_back(model(b));
         wait_done(30, lat);
      end
      start = 1'b0;
      spacing_on = 1'b0;
      repeat (5) @(negedge clk);
      check_val("q_drained_sweep", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the display path's binary-to-BCD split.
- Takes DIGITS packed BCD digits, e.g. hundreds/tens/units entered on switches or a keypad.
- Produces the equivalent unsigned binary value with a start/done handshake.
- Uses reverse double-dabble: shift right, then subtract 3 from each nibble that is 8 or more; one bit is resolved per clock.
- Feeds target/limit values into the accumulator and FSM blocks.

Parameters:
DIGITS, 3, number of BCD digits accepted.
BIN_W, 10, result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (10 for 3 digits).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
start  input  1  request conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD digits, most significant digit in the top nibble
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when result/err become valid
err  output  1  last request contained a nibble > 9; held until the next accepted start
result  output  BIN_W  binary value of the last conversion; held until the next accepted start

Behaviour:
- Reset values: when rst is low (asynchronous), state=IDLE, busy=0, done=0, err=0, result=0. Shift registers and the bit counter are cleared.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - With start=1 at a rising edge, bcd_in is captured into the 4*DIGITS shift register, the BIN_W binary register is cleared, and the counter is set to 0.
  - If any captured nibble is > 9: go to DONE with err=1 and result=0 (no CONVERT cycles).
  - Otherwise: go to CONVERT with err=0.
  - start=0: stay in IDLE.
- CONVERT, one step per cycle:
  - Shift the concatenation {bcd, bin} right by 1.
  - After the shift, any BCD nibble >= 8 has 3 subtracted, in the same cycle.
  - The counter increments; after BIN_W steps (counter == BIN_W-1 on the last step) go to DONE.
- DONE: lasts exactly one cycle.
  - done=1; result is loaded from the binary register (error case: result=0).
  - Next state is always IDLE.
- busy=1 in CONVERT and DONE; 0 in IDLE.
- Latency, for start high at edge N:
  - valid input: done=1 during the cycle after edge N+BIN_W, i.e. BIN_W+1 cycles after start; BIN_W=10 gives 11 cycles.
  - invalid input: done=1 one cycle after start.
- start while busy (CONVERT or DONE) is ignored and does not queue. bcd_in changes during conversion have no effect.
- result and err change only in the DONE cycle; between conversions they hold their values.
- Arithmetic: unsigned throughout. The nibble correction never underflows, since it applies only to nibbles >= 8. The result is exact for every valid input up to 10^DIGITS - 1.
- Reset mid-CONVERT: immediate return to IDLE with all outputs 0. No done pulse is generated for the aborted request.
- Back-to-back operation: holding start high continuously re-triggers from IDLE, one conversion per BIN_W+2 cycles.

Decomposition:
- Shared package/include: state encodings (IDLE=0, CONVERT=1, DONE=2), the DIGITS/BIN_W defaults, and a localparam for counter width = clog2(BIN_W).
- One natural sub-module, bcd_nibble_adj: combinational per-digit "if >= 8 subtract 3", instantiated DIGITS times via generate.
- Control FSM and datapath stay in bcd_to_bin_seq.

Test Plan:
- Reset, then bcd_in=12'h000 with a 1-cycle start -> busy for 11 cycles, done pulse in cycle 11, result=0, err=0.
- bcd_in=12'h999 -> result=999 (10'h3E7) at done; 12'h063 -> result=63; 12'h100 -> result=100.
- bcd_in=12'h0A5 -> done one cycle after start, err=1, result=0. A following valid 12'h042 -> err cleared, result=42.
- After start with 12'h500, pulse start again with 12'h123 at cycle 4 -> ignored; result=500 and exactly one done pulse.
- Drive rst low at cycle 5 of a conversion of 12'h777 -> busy=0, done never pulses, result=0. A fresh start with 12'h777 after release -> result=777.
- Exhaustive sweep 000..999 with back-to-back starts -> result equals the decimal value every time, done spacing = 12 cycles, err always 0.
